score_controller: RTL

//  Owns the game score and drives the 3-digit BCD score display (numbersToShow input of the display block).

---
 rtl/score_pkg.sv | 24 ++
 rtl/bcd_increment.sv | 28 ++
 rtl/score_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types for the score display path: BCD digit, multi-digit score and controller states.
// DIGITS sets the score width, 0 .. 10^DIGITS-1.
package score_pkg;

    localparam int DIGITS = 3;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [DIGITS-1:0] score_t;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } score_state_t;

    function automatic logic isMaxScore(input score_t s);
        logic m;
        m = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[i] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_increment.sv
// Combinational +1 on a multi-digit BCD score with a ripple 9->0 carry chain.
// carryOut is set when every digit wrapped.
module bcd_increment
    import score_pkg::*;
(
    input  score_t in,
    output score_t out,
    output logic   carryOut
);

    always_comb begin
        logic c;
        c   = 1'b1;
        out = in;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (in[i] == 4'd9) begin
                    out[i] = 4'd0;
                end else begin
                    out[i] = in[i] + 4'd1;
                    c      = 1'b0;
                end
            end
        end
        carryOut = c;
    end

endmodule

// File: rtl/score_controller.sv
// Score owner: queues point awards, drains them one BCD increment per clock, drives the digits.
// Optional blink after each change when SCORE_BLINK_EN is defined.
module score_controller
    import score_pkg::*;
#(
    parameter int POINTS_W     = 4,
    parameter int PENDING_W    = 8,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_HALF   = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  newGame,
    input  logic                  pointsValid,
    input  logic [POINTS_W-1:0]   points,
    input  logic                  startOfFrame,
    output logic [DIGITS*4-1:0]   numbersToShow,
    output logic                  busy,
    output logic                  saturated,
    output logic                  scoreVisible
);

    localparam logic [PENDING_W-1:0] PENDING_MAX = '1;

    score_state_t          state_q;
    score_t                digits_q;
    score_t                digits_inc;
    logic [PENDING_W-1:0]  pending_q;
    logic [PENDING_W-1:0]  pending_d;
    logic [PENDING_W:0]    pendingSum;
    logic                  saturated_q;
    logic                  scoreInc;
    logic                  unused_carry;

    bcd_increment u_inc (
        .in       (digits_q),
        .out      (digits_inc),
        .carryOut (unused_carry)
    );

    // Pending never underflows: ADD is only held while pending is non-zero.
    always_comb begin
        pendingSum = {1'b0, pending_q}
                   + (PENDING_W+1)'(pointsValid ? points : '0)
                   - (PENDING_W+1)'(state_q == ADD);
        pending_d  = pendingSum[PENDING_W] ? PENDING_MAX : pendingSum[PENDING_W-1:0];
        scoreInc   = (state_q == ADD) && !isMaxScore(digits_q) && !newGame;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            pending_q   <= '0;
            saturated_q <= 1'b0;
        end else if (newGame) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            pending_q   <= '0;
            saturated_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) state_q <= ADD;
                end
                ADD: begin
                    if (isMaxScore(digits_q)) saturated_q <= 1'b1;
                    else                      digits_q    <= digits_inc;
                    if (pending_d == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign numbersToShow = digits_q;
    assign busy          = (state_q == ADD) || (pending_q != '0);
    assign saturated     = saturated_q;

`ifdef SCORE_BLINK_EN
    localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);
    localparam int HCNT_W = $clog2(BLINK_HALF + 1);
    localparam logic [BCNT_W-1:0] BLINK_LOAD = BCNT_W'(BLINK_FRAMES);
    localparam logic [HCNT_W-1:0] HALF_LAST  = HCNT_W'(BLINK_HALF - 1);

    logic [BCNT_W-1:0] blinkCnt_q;
    logic [HCNT_W-1:0] halfCnt_q;
    logic              phase_q;

    // Every score change restarts the blink in its invisible half.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blinkCnt_q <= '0;
            halfCnt_q  <= '0;
            phase_q    <= 1'b0;
        end else if (newGame) begin
            blinkCnt_q <= '0;
            halfCnt_q  <= '0;
            phase_q    <= 1'b0;
        end else if (scoreInc) begin
            blinkCnt_q <= BLINK_LOAD;
            halfCnt_q  <= '0;
            phase_q    <= 1'b0;
        end else if (startOfFrame && (blinkCnt_q != '0)) begin
            blinkCnt_q <= blinkCnt_q - BCNT_W'(1);
            if (halfCnt_q == HALF_LAST) begin
                halfCnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                halfCnt_q <= halfCnt_q + HCNT_W'(1);
            end
        end
    end

    assign scoreVisible = (blinkCnt_q == '0) || phase_q;
`else
    localparam int unused_blink_cfg = BLINK_FRAMES + BLINK_HALF;
    logic unused_sof;
    logic unused_inc;
    assign unused_sof   = startOfFrame;
    assign unused_inc   = scoreInc;
    assign scoreVisible = 1'b1;
`endif

endmodule
